// File: rtl/rgb_stream_sequencer_if.sv
// Pixel stream bundle: 24-bit {R,G,B} pixels with valid/ready
// handshake and an end-of-frame qualifier.
interface rgb_stream_sequencer_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;

  modport master (
    output pix_data,
    output pix_valid,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/rgb_stream_sequencer.sv
// Frame readout: vector-reads R/G/B planes 4 pixels at a time,
// merges them into {R,G,B} pixels and streams them out.
module rgb_stream_sequencer #(
  parameter int PIX_COUNT = 40000,
  parameter int R_BASE    = 0,
  parameter int G_BASE    = 40000,
  parameter int B_BASE    = 80000,
  parameter int IDX_W     = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  output logic         mem_own,
  output logic [127:0] mem_addr,
  output logic         mem_we,
  output logic         mem_vf,
  input  logic [127:0] mem_rd,
  rgb_stream_sequencer_if.master pix,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE, RD_R, RD_G, RD_B, CAP_B, EMIT, DONE
  } state_e;

  localparam logic [127:0] R_A = 128'(R_BASE);
  localparam logic [127:0] G_A = 128'(G_BASE);
  localparam logic [127:0] B_A = 128'(B_BASE);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(PIX_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_COUNT - 4);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic [1:0]       lane_q, lane_d;
  logic [3:0][7:0]  r_q, r_d;
  logic [3:0][7:0]  g_q, g_d;
  logic [3:0][7:0]  b_q, b_d;
  logic [3:0][7:0]  rd_lane;
  logic             xfer, grp_end, last_grp;
  logic             unused_rd;

  // only the low byte of each 32-bit lane carries pixel data
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_lane[k] = mem_rd[32*k +: 8];
    end
  end

  assign unused_rd = ^{mem_rd[127:104], mem_rd[95:72],
                       mem_rd[63:40], mem_rd[31:8]};

  assign xfer     = (state_q == EMIT) && pix.pix_ready;
  assign grp_end  = xfer && (lane_q == 2'd3);
  assign idx_nxt  = idx_q + IDX_W'(4);
  assign last_grp = (idx_nxt == END_IDX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start && !abort) state_d = RD_R;
        RD_R:    state_d = RD_G;
        RD_G:    state_d = RD_B;
        RD_B:    state_d = CAP_B;
        CAP_B:   state_d = EMIT;
        EMIT:    if (grp_end) state_d = last_grp ? DONE : RD_R;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q  <= '0;
      lane_q <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      idx_q  <= idx_d;
      lane_q <= lane_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  // each plane's data lands one cycle after its address was issued
  always_comb begin
    idx_d  = idx_q;
    lane_d = lane_q;
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    if (state_q == IDLE && start) idx_d = '0;
    if (state_q == RD_G) r_d = rd_lane;
    if (state_q == RD_B) g_d = rd_lane;
    if (state_q == CAP_B) begin
      b_d    = rd_lane;
      lane_d = '0;
    end
    if (xfer) lane_d = lane_q + 2'd1;
    if (grp_end) idx_d = idx_nxt;
    if (abort) lane_d = '0;
  end

  always_comb begin
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_own       = !(state_q inside {IDLE, DONE});
    mem_vf        = mem_own;
    pix.pix_valid = 1'b0;
    pix.pix_data  = '0;
    pix.pix_last  = 1'b0;
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    unique case (state_q)
      RD_R:        mem_addr = R_A + 128'(idx_q);
      RD_G:        mem_addr = G_A + 128'(idx_q);
      RD_B, CAP_B: mem_addr = B_A + 128'(idx_q);
      EMIT: begin
        mem_addr      = B_A + 128'(idx_q);
        pix.pix_valid = 1'b1;
        pix.pix_data  = {r_q[lane_q], g_q[lane_q], b_q[lane_q]};
        pix.pix_last  = (lane_q == 2'd3) && (idx_q == LAST_IDX);
      end
      default: ;
    endcase
  end

endmodule
